// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA decryption engine: default width, FSM
// state encoding and the accumulator width helper for the modular multiplier.
package rsa_pkg;

    localparam int BITS_DEFAULT = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SQR  = 3'd2,
        ST_MUL  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // The multiplier intermediate stays below 3n, so two extra bits suffice.
    function automatic int acc_w(input int bits);
        return bits + 2;
    endfunction

    localparam int ACC_W = BITS_DEFAULT + 2;

endpackage

// File: rtl/rsa_decrypt_mod_mult.sv
// Bit-serial interleaved modular multiplier: p = a*b mod n, scanning b MSB first.
// The first step runs on the start edge, so mm_valid pulses BITS cycles after start.
module mod_mult
    import rsa_pkg::*;
#(
    parameter int BITS = BITS_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic [BITS-1:0] n,
    output logic [BITS-1:0] p,
    output logic            mm_valid
);
    localparam int AW = acc_w(BITS);
    localparam int CW = $clog2(BITS + 1);

    logic [AW-1:0]   p_q, a_q, n_q;
    logic [BITS-1:0] b_q;
    logic [CW-1:0]   cnt_q;
    logic            run_q, valid_q;

    logic [AW-1:0] p_src, a_src, n_src, sum, red1, p_d;
    logic          b_bit;

    // A start overrides any running operation: the step uses fresh operands.
    always_comb begin
        p_src = start ? '0 : p_q;
        a_src = start ? AW'(a) : a_q;
        n_src = start ? AW'(n) : n_q;
        b_bit = start ? b[BITS-1] : b_q[BITS-1];
        sum   = {p_src[AW-2:0], 1'b0} + (b_bit ? a_src : '0);
        red1  = (sum >= n_src) ? sum - n_src : sum;
        p_d   = (red1 >= n_src) ? red1 - n_src : red1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p_q     <= '0;
            a_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (start) begin
                p_q   <= p_d;
                a_q   <= AW'(a);
                n_q   <= AW'(n);
                b_q   <= {b[BITS-2:0], 1'b0};
                cnt_q <= CW'(BITS - 1);
                run_q <= 1'b1;
            end else if (run_q) begin
                p_q   <= p_d;
                b_q   <= {b_q[BITS-2:0], 1'b0};
                cnt_q <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    run_q   <= 1'b0;
                    valid_q <= 1'b1;
                end
            end
        end
    end

    assign p        = p_q[BITS-1:0];
    assign mm_valid = valid_q;

endmodule

// File: rtl/rsa_decrypt.sv
// Constant-time RSA decryption r = c^dk mod n by left-to-right square-and-multiply;
// every exponent bit costs one square and one (possibly discarded) multiply.
module rsa_decrypt
    import rsa_pkg::*;
#(
    parameter int BITS = BITS_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            go,
    input  logic [BITS-1:0] c,
    input  logic [BITS-1:0] dk,
    input  logic [BITS-1:0] n,
    output logic [BITS-1:0] r,
    output logic            done,
    output logic            busy,
    output logic            err
);
    localparam int KW = $clog2(BITS);

    state_e          state_q;
    logic [BITS-1:0] c_q, dk_q, n_q, acc_q, r_q;
    logic [KW-1:0]   k_q;
    logic            done_q, busy_q, err_q;
    logic            mm_start_q;
    logic [BITS-1:0] mm_a_q, mm_b_q, mm_p;
    logic            mm_valid;
    logic [BITS-1:0] acc_d;

    mod_mult #(.BITS(BITS)) u_mm (
        .clk      (clk),
        .reset    (reset),
        .start    (mm_start_q),
        .a        (mm_a_q),
        .b        (mm_b_q),
        .n        (n_q),
        .p        (mm_p),
        .mm_valid (mm_valid)
    );

    // The multiply result is only kept when the current exponent bit is set.
    assign acc_d = dk_q[k_q] ? mm_p : acc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            c_q        <= '0;
            dk_q       <= '0;
            n_q        <= '0;
            acc_q      <= '0;
            k_q        <= '0;
            r_q        <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            mm_start_q <= 1'b0;
            mm_a_q     <= '0;
            mm_b_q     <= '0;
        end else begin
            done_q     <= 1'b0;
            mm_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (go) begin
                        c_q     <= c;
                        dk_q    <= dk;
                        n_q     <= n;
                        busy_q  <= 1'b1;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (n_q < BITS'(2) || c_q >= n_q) begin
                        r_q     <= '0;
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        acc_q      <= BITS'(1);
                        k_q        <= KW'(BITS - 1);
                        mm_start_q <= 1'b1;
                        mm_a_q     <= BITS'(1);
                        mm_b_q     <= BITS'(1);
                        state_q    <= ST_SQR;
                    end
                end
                ST_SQR: begin
                    if (mm_valid) begin
                        acc_q      <= mm_p;
                        mm_start_q <= 1'b1;
                        mm_a_q     <= mm_p;
                        mm_b_q     <= c_q;
                        state_q    <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    if (mm_valid) begin
                        acc_q <= acc_d;
                        if (k_q == '0) begin
                            r_q     <= acc_d;
                            err_q   <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            k_q        <= k_q - KW'(1);
                            mm_start_q <= 1'b1;
                            mm_a_q     <= acc_d;
                            mm_b_q     <= acc_d;
                            state_q    <= ST_SQR;
                        end
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign r    = r_q;
    assign done = done_q;
    assign busy = busy_q;
    assign err  = err_q;

endmodule

// File: tb/tb_rsa_decrypt.sv
// Scoreboard bench for rsa_decrypt: expectations are queued on go acceptance
// and compared (value, error flag, completion cycle) when done pulses.
module tb_rsa_decrypt;
    localparam int BITS = 4;
    localparam int LAT  = 2 + 2 * BITS * (BITS + 1);

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            go = 1'b0;
    logic [BITS-1:0] c = '0, dk = '0, n = '0;
    logic [BITS-1:0] r;
    logic            done, busy, err;

    rsa_decrypt #(.BITS(BITS)) dut (
        .clk   (clk),
        .reset (reset),
        .go    (go),
        .c     (c),
        .dk    (dk),
        .n     (n),
        .r     (r),
        .done  (done),
        .busy  (busy),
        .err   (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int c; int dk; int n; int r; int e; int due;
    } exp_t;
    exp_t sbq[$];

    int n_checks = 0, n_errors = 0;
    int acc_cnt = 0, last_acc = 0;
    bit mon_en = 1'b0;
    bit bz = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int powmod(input int b, input int e, input int m);
        int res = 1;
        for (int i = 0; i < e; i++) res = (res * b) % m;
        return res;
    endfunction

    // Monitor and acceptor share one sampling point to keep their order fixed.
    always @(negedge clk) begin
        if (mon_en) begin
            if (reset) begin
                sbq.delete();
                bz = 1'b0;
            end else begin
                check("busy", busy, bz);
                if (done) begin
                    if (sbq.size() == 0) begin
                        check("spurious_done", 1, 0);
                    end else begin
                        exp_t x;
                        x = sbq.pop_front();
                        $display("job c=%0d dk=%0d n=%0d -> r=%0d err=%0d at cycle %0d",
                                 x.c, x.dk, x.n, r, err, cyc);
                        check("r", r, x.r);
                        check("err", err, x.e);
                        check("done_cycle", cyc, x.due);
                    end
                    bz = 1'b0;
                end
                if (go && !busy) begin
                    exp_t x;
                    x.c = int'(c); x.dk = int'(dk); x.n = int'(n);
                    x.e = (x.n < 2 || x.c >= x.n) ? 1 : 0;
                    x.r = x.e ? 0 : powmod(x.c, x.dk, x.n);
                    x.due = cyc + (x.e ? 2 : LAT);
                    sbq.push_back(x);
                    acc_cnt++;
                    last_acc = cyc;
                    bz = 1'b1;
                end
            end
        end
    end

    task automatic job(input int cv, input int dv, input int nv, input bit hold);
        int old;
        int k;
        @(posedge clk); #2;
        c = BITS'(cv); dk = BITS'(dv); n = BITS'(nv);
        go = 1'b1;
        old = acc_cnt;
        k = 0;
        while (acc_cnt == old && k < 300) begin
            @(posedge clk); #2;
            k++;
        end
        if (acc_cnt == old) check("accept_timeout", 0, 1);
        if (!hold) go = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (sbq.size() != 0 && k < 500) begin
            @(posedge clk); #2;
            k++;
        end
        if (sbq.size() != 0) check("drain_timeout", sbq.size(), 0);
    endtask

    task automatic wait_cycle(input int target);
        while (cyc < target) begin
            @(posedge clk); #2;
        end
    endtask

    initial begin
        int t0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_r", r, 0);
        check("reset_done", done, 0);
        check("reset_busy", busy, 0);
        check("reset_err", err, 0);
        @(posedge clk); #2;
        reset = 1'b0;
        mon_en = 1'b1;

        job(13, 3, 15, 0); drain();
        job(2, 15, 15, 0); drain();
        job(5, 0, 14, 0);  drain();
        job(15, 5, 15, 0); drain();
        job(0, 3, 1, 0);   drain();
        job(0, 5, 15, 0);  drain();
        job(0, 0, 15, 0);  drain();
        job(7, 13, 15, 0); drain();
        job(11, 6, 13, 0); drain();

        // Abort an in-flight job with reset; a go pulse while busy is ignored.
        job(13, 3, 15, 0);
        t0 = last_acc;
        wait_cycle(t0 + 10);
        go = 1'b1;
        @(posedge clk); #2;
        go = 1'b0;
        wait_cycle(t0 + 20);
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        @(negedge clk);
        check("abort_r", r, 0);
        check("abort_done", done, 0);
        check("abort_busy", busy, 0);
        check("abort_err", err, 0);
        wait_cycle(t0 + 24);
        job(13, 3, 15, 0);
        check("restart_accept", last_acc - t0, 25);
        drain();

        // Round trip with go held high: jobs run back to back.
        for (int m = 0; m < 15; m++) begin
            job(powmod(m, 3, 15), 3, 15, m != 14);
        end
        drain();

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
